// File: rtl/pipe_skid_reg.sv
// pipe_skid_reg: valid/ready pipeline stage register with 2-entry skid buffer, flush and event counters
module pipe_skid_reg #(
  parameter int DATA_WIDTH    = 97,
  parameter int LANES         = 2,
  parameter int ZERO_ON_FLUSH = 1,
  parameter int CNT_W         = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        flush,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [LANES-1:0]            in_lane_vld,
  input  logic [LANES*DATA_WIDTH-1:0] in_data,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [LANES-1:0]            out_lane_vld,
  output logic [LANES*DATA_WIDTH-1:0] out_data,
  output logic [CNT_W-1:0]            stall_cnt,
  output logic [CNT_W-1:0]            flush_cnt
);
  localparam int W = LANES*DATA_WIDTH;
  logic             main_v_q, main_v_d, skid_v_q, skid_v_d;
  logic [LANES-1:0] main_m_q, main_m_d, skid_m_q, skid_m_d;
  logic [W-1:0]     main_dat_q, main_dat_d, skid_dat_q, skid_dat_d;
  logic [CNT_W-1:0] stall_q, stall_d, flcnt_q, flcnt_d;
  logic             accept, store, pop;
  assign in_ready     = ~skid_v_q;
  assign accept       = in_valid & in_ready & ~rst;
  assign store        = accept & |in_lane_vld;
  assign pop          = main_v_q & out_ready;
  assign out_valid    = main_v_q;
  assign out_lane_vld = main_m_q;
  assign out_data     = main_dat_q;
  assign stall_cnt    = stall_q;
  assign flush_cnt    = flcnt_q;
  always_comb begin
    main_v_d   = main_v_q;
    main_m_d   = main_m_q;
    main_dat_d = main_dat_q;
    skid_v_d   = skid_v_q;
    skid_m_d   = skid_m_q;
    skid_dat_d = skid_dat_q;
    stall_d    = stall_q + CNT_W'(main_v_q & ~out_ready & ~flush & ~&stall_q);
    flcnt_d    = flcnt_q + CNT_W'(flush & (main_v_q | skid_v_q) & ~&flcnt_q);
    if (flush) begin
      main_v_d = 1'b0;
      skid_v_d = 1'b0;
      main_m_d = '0;
      skid_m_d = '0;
      if (ZERO_ON_FLUSH != 0) begin
        main_dat_d = '0;
        skid_dat_d = '0;
      end
    end else if (!main_v_q || pop) begin
      // main refills from skid first to preserve acceptance order
      main_v_d   = skid_v_q | store;
      main_m_d   = skid_v_q ? skid_m_q : store ? in_lane_vld : '0;
      main_dat_d = skid_v_q ? skid_dat_q : store ? in_data : main_dat_q;
      skid_v_d   = 1'b0;
      skid_m_d   = '0;
    end else if (store) begin
      skid_v_d   = 1'b1;
      skid_m_d   = in_lane_vld;
      skid_dat_d = in_data;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      main_v_q   <= 1'b0;
      main_m_q   <= '0;
      main_dat_q <= '0;
      skid_v_q   <= 1'b0;
      skid_m_q   <= '0;
      skid_dat_q <= '0;
      stall_q    <= '0;
      flcnt_q    <= '0;
    end else begin
      main_v_q   <= main_v_d;
      main_m_q   <= main_m_d;
      main_dat_q <= main_dat_d;
      skid_v_q   <= skid_v_d;
      skid_m_q   <= skid_m_d;
      skid_dat_q <= skid_dat_d;
      stall_q    <= stall_d;
      flcnt_q    <= flcnt_d;
    end
  end
endmodule

// File: tb/tb_pipe_skid_reg.sv
// tb_pipe_skid_reg: directed vector table plus randomized run against a queue-based reference model
module tb_pipe_skid_reg;
  localparam int DW = 97;
  localparam int L  = 2;
  localparam int CW = 4;
  localparam int W  = L*DW;
  logic          clk = 0, rst = 1, flush = 0, in_valid = 0, out_ready = 0;
  logic          in_ready, out_valid;
  logic [L-1:0]  in_lane_vld = '0, out_lane_vld;
  logic [W-1:0]  in_data = '0, out_data;
  logic [CW-1:0] stall_cnt, flush_cnt;
  int checks = 0, errors = 0;
  pipe_skid_reg #(.DATA_WIDTH(DW), .LANES(L), .ZERO_ON_FLUSH(1), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_lane_vld(in_lane_vld), .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_lane_vld(out_lane_vld), .out_data(out_data), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );
  always #5 clk = ~clk;
  typedef struct {
    logic r, f, iv;
    logic [1:0] m;
    logic [DW-1:0] d;
    logic ordy, eov, eir;
    logic [1:0] em;
    logic [DW-1:0] ed;
    logic [CW-1:0] est, efl;
    logic z;
  } vec_t;
  typedef struct {
    logic [1:0] m;
    logic [W-1:0] d;
  } bq_t;
  vec_t tbl[$];
  bq_t  q[$];
  int   mst, mfl;
  function automatic logic [W-1:0] pack(input logic [DW-1:0] d);
    logic [DW-1:0] h;
    h = d << 8;
    return {h, d};
  endfunction
  function automatic void add(input logic r, f, iv, input logic [1:0] m, input logic [DW-1:0] d,
                              input logic ordy, eov, eir, input logic [1:0] em,
                              input logic [DW-1:0] ed, input logic [CW-1:0] est, efl, input logic z);
    vec_t v;
    v.r = r; v.f = f; v.iv = iv; v.m = m; v.d = d; v.ordy = ordy;
    v.eov = eov; v.eir = eir; v.em = em; v.ed = ed; v.est = est; v.efl = efl; v.z = z;
    tbl.push_back(v);
  endfunction
  task automatic chk(input string n, input logic [W-1:0] a, input logic [W-1:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", n, a, e);
    end
  endtask
  initial begin
    // reset
    add(1,0,0,2'b00,0,    1, 0,1,2'b00,0,    0,0,1);
    // streaming
    for (int i = 1; i <= 8; i++) add(0,0,1,2'b11,DW'(i), 1, 1,1,2'b11,DW'(i), 0,0,0);
    add(0,0,0,2'b00,0,    1, 0,1,2'b00,0,    0,0,0);
    // backpressure A,B,C
    add(0,0,1,2'b11,'h10, 0, 1,1,2'b11,'h10, 0,0,0);
    add(0,0,1,2'b11,'h11, 0, 1,0,2'b11,'h10, 1,0,0);
    add(0,0,1,2'b11,'h12, 0, 1,0,2'b11,'h10, 2,0,0);
    add(0,0,1,2'b11,'h12, 1, 1,1,2'b11,'h11, 2,0,0);
    add(0,0,1,2'b11,'h12, 1, 1,1,2'b11,'h12, 2,0,0);
    add(0,0,0,2'b00,0,    1, 0,1,2'b00,0,    2,0,0);
    // flush while full, incoming bundle dropped
    add(0,0,1,2'b11,'h20, 0, 1,1,2'b11,'h20, 2,0,0);
    add(0,0,1,2'b11,'h21, 0, 1,0,2'b11,'h20, 3,0,0);
    add(0,1,1,2'b11,'h22, 0, 0,1,2'b00,0,    3,1,1);
    add(0,0,0,2'b00,0,    1, 0,1,2'b00,0,    3,1,1);
    // partial lanes
    add(0,0,1,2'b01,'h31, 1, 1,1,2'b01,'h31, 3,1,0);
    add(0,0,1,2'b00,'h32, 1, 0,1,2'b00,0,    3,1,0);
    add(0,0,1,2'b10,'h33, 1, 1,1,2'b10,'h33, 3,1,0);
    add(0,0,0,2'b00,0,    1, 0,1,2'b00,0,    3,1,0);
    // reset while full
    add(0,0,1,2'b11,'h40, 0, 1,1,2'b11,'h40, 3,1,0);
    add(0,0,1,2'b11,'h41, 0, 1,0,2'b11,'h40, 4,1,0);
    add(1,0,1,2'b11,'h42, 0, 0,1,2'b00,0,    0,0,1);
    add(0,0,1,2'b11,'h43, 0, 1,1,2'b11,'h43, 0,0,0);
    add(0,0,0,2'b00,0,    1, 0,1,2'b00,0,    0,0,0);
    // stall counter saturation
    add(0,0,1,2'b11,'h50, 0, 1,1,2'b11,'h50, 0,0,0);
    for (int i = 1; i <= 20; i++)
      add(0,0,0,2'b00,0, 0, 1,1,2'b11,'h50, CW'(i > 15 ? 15 : i),0,0);
    add(0,0,0,2'b00,0,    1, 0,1,2'b00,0,    15,0,0);
    foreach (tbl[i]) begin
      @(negedge clk);
      rst = tbl[i].r; flush = tbl[i].f; in_valid = tbl[i].iv; in_lane_vld = tbl[i].m;
      in_data = pack(tbl[i].d); out_ready = tbl[i].ordy;
      @(posedge clk);
      #1;
      chk($sformatf("v%0d out_valid", i), W'(out_valid), W'(tbl[i].eov));
      chk($sformatf("v%0d in_ready", i), W'(in_ready), W'(tbl[i].eir));
      chk($sformatf("v%0d stall_cnt", i), W'(stall_cnt), W'(tbl[i].est));
      chk($sformatf("v%0d flush_cnt", i), W'(flush_cnt), W'(tbl[i].efl));
      if (tbl[i].eov || tbl[i].z) begin
        chk($sformatf("v%0d out_lane_vld", i), W'(out_lane_vld), W'(tbl[i].em));
        chk($sformatf("v%0d out_data", i), out_data, pack(tbl[i].ed));
      end
    end
    // randomized run against the queue model; first cycle resets both sides
    for (int i = 0; i < 600; i++) begin
      bq_t b;
      logic [DW-1:0] d;
      @(negedge clk);
      rst = (i == 0) || ($urandom_range(63) == 0);
      flush = ($urandom_range(15) == 0);
      in_valid = ($urandom_range(2) != 0);
      in_lane_vld = L'($urandom_range(3));
      d = {$urandom, $urandom, $urandom, $urandom};
      in_data = {d ^ DW'($urandom), d};
      out_ready = ($urandom_range(3) != 0);
      if (i > 0) begin
        chk($sformatf("r%0d out_valid", i), W'(out_valid), W'(q.size() > 0));
        chk($sformatf("r%0d in_ready", i), W'(in_ready), W'(q.size() < 2));
        chk($sformatf("r%0d stall_cnt", i), W'(stall_cnt), W'(mst));
        chk($sformatf("r%0d flush_cnt", i), W'(flush_cnt), W'(mfl));
        if (q.size() > 0) begin
          chk($sformatf("r%0d out_lane_vld", i), W'(out_lane_vld), W'(q[0].m));
          chk($sformatf("r%0d out_data", i), out_data, q[0].d);
        end
      end
      if (rst) begin
        q.delete(); mst = 0; mfl = 0;
      end else begin
        if (q.size() > 0 && !out_ready && !flush && mst < 15) mst++;
        if (flush && q.size() > 0 && mfl < 15) mfl++;
        if (flush) q.delete();
        else begin
          b.m = in_lane_vld; b.d = in_data;
          if (q.size() > 0 && out_ready) void'(q.pop_front());
          else if (in_valid && q.size() < 2 && in_lane_vld != 0 && q.size() == 1) q.push_back(b);
          if (in_valid && in_lane_vld != 0 && q.size() == 0) q.push_back(b);
        end
      end
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
